// File: rtl/song_sequencer_pkg.sv
// Shared types, constants and helpers for the auto-play note sequencer.
package song_sequencer_pkg;

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StPlay, StPause} state_e;

  localparam logic [3:0] NOTE_REST = 4'h0;
  localparam logic [3:0] NOTE_END  = 4'hF;

  localparam logic [1:0] SPD_SLOW = 2'd0;
  localparam logic [1:0] SPD_NORM = 2'd1;
  localparam logic [1:0] SPD_FAST = 2'd2;

  // rom_data = {octave, note, dur}; the dur field width sets the other offsets
  localparam int unsigned NOTE_W = 4;
  localparam int unsigned OCT_W  = 2;

  function automatic int unsigned note_lsb(input int unsigned dur_w);
    return dur_w;
  endfunction

  function automatic int unsigned oct_lsb(input int unsigned dur_w);
    return dur_w + NOTE_W;
  endfunction

  function automatic logic [6:0] note_to_led(input logic [3:0] note);
    logic [6:0] led;
    led = 7'b0;
    case (note)
      4'd1: led = 7'b000_0001;
      4'd2: led = 7'b000_0010;
      4'd3: led = 7'b000_0100;
      4'd4: led = 7'b000_1000;
      4'd5: led = 7'b001_0000;
      4'd6: led = 7'b010_0000;
      4'd7: led = 7'b100_0000;
      default: led = 7'b0;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/song_sequencer_beat_timer.sv
// Beat prescaler: one-cycle beat pulse every beat length; restarts on start, holds when not running.
module song_sequencer_beat_timer
  import song_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       run,
  input  logic [1:0] speed_idx,
  output logic       beat
);

  localparam int unsigned CNT_W = $clog2(2 * TICK_DIV);

  logic [CNT_W-1:0] cnt_q, last_q, last_sel;

  always_comb begin
    last_sel = CNT_W'(TICK_DIV - 1);
    case (speed_idx)
      SPD_SLOW: last_sel = CNT_W'(2 * TICK_DIV - 1);
      SPD_FAST: last_sel = CNT_W'(TICK_DIV / 2 - 1);
      default:  last_sel = CNT_W'(TICK_DIV - 1);
    endcase
  end

  assign beat = run && !start && (cnt_q == last_q);

  // Beat length is latched only at start and on beat boundaries
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      last_q <= CNT_W'(TICK_DIV - 1);
    end else if (start) begin
      cnt_q  <= '0;
      last_q <= last_sel;
    end else if (run) begin
      if (cnt_q == last_q) begin
        cnt_q  <= '0;
        last_q <= last_sel;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Auto-play note sequencer: fetches note words from a synchronous ROM and drives buzzer and LEDs.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 10_000_000,
  parameter int unsigned SONG_LEN  = 56,
  parameter int unsigned NUM_SONGS = 6,
  parameter int unsigned DUR_W     = 4,
  localparam int unsigned SONG_W   = $clog2(NUM_SONGS),
  localparam int unsigned POS_W    = $clog2(SONG_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_btn,
  input  logic [1:0]        song_btn,
  input  logic [1:0]        speed_btn,
  input  logic              loop_en,
  output logic [SONG_W-1:0] rom_song,
  output logic [POS_W-1:0]  rom_pos,
  input  logic [5+DUR_W:0]  rom_data,
  output logic [3:0]        note_out,
  output logic [1:0]        octave_out,
  output logic [6:0]        led_out,
  output logic [SONG_W-1:0] song_idx,
  output logic [1:0]        speed_idx,
  output logic              playing,
  output logic              song_done
);

  localparam int unsigned NOTE_LSB = note_lsb(DUR_W);
  localparam int unsigned OCT_LSB  = oct_lsb(DUR_W);

  state_e            state_q, state_d;
  logic              play_prev_q;
  logic [1:0]        song_prev_q, speed_prev_q;
  logic [SONG_W-1:0] song_q, song_d;
  logic [1:0]        speed_q, speed_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [3:0]        note_q, note_d;
  logic [1:0]        oct_q, oct_d;
  logic [DUR_W-1:0]  dur_q, dur_d, beat_cnt_q, beat_cnt_d, dur_eff;
  logic [3:0]        note_out_q;
  logic [1:0]        octave_out_q;
  logic [6:0]        led_q;
  logic              playing_q, done_q, done_d, out_on, song_end;

  logic [3:0]       rom_note;
  logic [1:0]       rom_oct;
  logic [DUR_W-1:0] rom_dur;
  assign rom_note = rom_data[NOTE_LSB +: NOTE_W];
  assign rom_oct  = rom_data[OCT_LSB +: OCT_W];
  assign rom_dur  = rom_data[DUR_W-1:0];

  logic play_edge, song_next, song_prev, song_step, spd_up, spd_dn;
  assign play_edge = play_btn & ~play_prev_q;
  assign song_next = song_btn[0] & ~song_prev_q[0];
  assign song_prev = song_btn[1] & ~song_prev_q[1];
  assign song_step = song_next | song_prev;
  assign spd_up    = speed_btn[0] & ~speed_prev_q[0];
  assign spd_dn    = speed_btn[1] & ~speed_prev_q[1];

  assign dur_eff = (dur_q == '0) ? DUR_W'(1) : dur_q;

  logic beat, run, start;
  assign start = (state_q == StLoad);
  // Gate the timer on a pause edge so a beat landing on that cycle is not lost
  assign run   = (state_q == StPlay) && !play_edge && !song_step;

  song_sequencer_beat_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_beat_timer (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .run      (run),
    .speed_idx(speed_q),
    .beat     (beat)
  );

  always_comb begin
    state_d    = state_q;
    song_d     = song_q;
    speed_d    = speed_q;
    pos_d      = pos_q;
    note_d     = note_q;
    oct_d      = oct_q;
    dur_d      = dur_q;
    beat_cnt_d = beat_cnt_q;
    done_d     = 1'b0;
    song_end   = 1'b0;

    if (spd_up) begin
      speed_d = (speed_q == SPD_FAST) ? SPD_SLOW : speed_q + 2'd1;
    end else if (spd_dn) begin
      speed_d = (speed_q == SPD_SLOW) ? SPD_FAST : speed_q - 2'd1;
    end

    if (song_step) begin
      if (song_next) begin
        song_d = (song_q == SONG_W'(NUM_SONGS - 1)) ? '0 : song_q + 1'b1;
      end else begin
        song_d = (song_q == '0) ? SONG_W'(NUM_SONGS - 1) : song_q - 1'b1;
      end
      if (state_q != StIdle) begin
        state_d = StFetch;
        pos_d   = '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (play_edge) begin
            state_d = StFetch;
            pos_d   = '0;
          end
        end
        StFetch: state_d = StLoad;
        StLoad: begin
          if (rom_note == NOTE_END) begin
            song_end = 1'b1;
          end else begin
            note_d     = rom_note;
            oct_d      = rom_oct;
            dur_d      = rom_dur;
            beat_cnt_d = '0;
            state_d    = StPlay;
          end
        end
        StPlay: begin
          if (play_edge) begin
            state_d = StPause;
          end else if (beat) begin
            if (beat_cnt_q + 1'b1 == dur_eff) begin
              if (pos_q == POS_W'(SONG_LEN - 1)) begin
                song_end = 1'b1;
              end else begin
                pos_d   = pos_q + 1'b1;
                state_d = StFetch;
              end
            end else begin
              beat_cnt_d = beat_cnt_q + 1'b1;
            end
          end
        end
        StPause: begin
          if (play_edge) state_d = StPlay;
        end
        default: state_d = StIdle;
      endcase

      if (song_end) begin
        pos_d = '0;
        if (loop_en) begin
          state_d = StFetch;
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
          note_d  = NOTE_REST;
          oct_d   = '0;
        end
      end
    end

    out_on = (state_d == StFetch) || (state_d == StLoad) || (state_d == StPlay);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      play_prev_q  <= 1'b0;
      song_prev_q  <= '0;
      speed_prev_q <= '0;
      song_q       <= '0;
      speed_q      <= SPD_NORM;
      pos_q        <= '0;
      note_q       <= NOTE_REST;
      oct_q        <= '0;
      dur_q        <= '0;
      beat_cnt_q   <= '0;
      note_out_q   <= NOTE_REST;
      octave_out_q <= '0;
      led_q        <= '0;
      playing_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      play_prev_q  <= play_btn;
      song_prev_q  <= song_btn;
      speed_prev_q <= speed_btn;
      song_q       <= song_d;
      speed_q      <= speed_d;
      pos_q        <= pos_d;
      note_q       <= note_d;
      oct_q        <= oct_d;
      dur_q        <= dur_d;
      beat_cnt_q   <= beat_cnt_d;
      note_out_q   <= out_on ? note_d : NOTE_REST;
      octave_out_q <= out_on ? oct_d : 2'b0;
      led_q        <= out_on ? note_to_led(note_d) : 7'b0;
      playing_q    <= out_on;
      done_q       <= done_d;
    end
  end

  assign rom_song   = song_q;
  assign rom_pos    = pos_q;
  assign song_idx   = song_q;
  assign speed_idx  = speed_q;
  assign note_out   = note_out_q;
  assign octave_out = octave_out_q;
  assign led_out    = led_q;
  assign playing    = playing_q;
  assign song_done  = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: expected output events queued by stimulus, checked by a monitor.
module tb_song_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       play_btn, loop_en;
  logic [1:0] song_btn, speed_btn;
  logic [1:0] rom_song;
  logic [2:0] rom_pos;
  logic [9:0] rom_data = '0;
  logic [3:0] note_out;
  logic [1:0] octave_out;
  logic [6:0] led_out;
  logic [1:0] song_idx;
  logic [1:0] speed_idx;
  logic       playing, song_done;

  logic [9:0] rom [3][8];

  song_sequencer #(
    .TICK_DIV (4),
    .SONG_LEN (8),
    .NUM_SONGS(3),
    .DUR_W    (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .play_btn  (play_btn),
    .song_btn  (song_btn),
    .speed_btn (speed_btn),
    .loop_en   (loop_en),
    .rom_song  (rom_song),
    .rom_pos   (rom_pos),
    .rom_data  (rom_data),
    .note_out  (note_out),
    .octave_out(octave_out),
    .led_out   (led_out),
    .song_idx  (song_idx),
    .speed_idx (speed_idx),
    .playing   (playing),
    .song_done (song_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_song][rom_pos];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h), cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int led_of(input int n);
    return (n >= 1 && n <= 7) ? (1 << (n - 1)) : 0;
  endfunction

  function automatic int ev(input int n, input int o, input int l, input int d);
    return (n << 10) | (o << 8) | (l << 1) | d;
  endfunction

  function automatic logic [9:0] w(input int o, input int n, input int d);
    return {2'(o), 4'(n), 4'(d)};
  endfunction

  task automatic push(input int c, input int n, input int o, input int d);
    exp_t e;
    e.cyc = c;
    e.val = ev(n, o, led_of(n), d);
    sb.push_back(e);
  endtask

  // Event = change of note/octave/led, or song_done high
  initial begin : monitor
    int   act;
    int   prev_ev;
    exp_t e;
    prev_ev = 0;
    forever begin
      @(negedge clk);
      act = ev(int'(note_out), int'(octave_out), int'(led_out), int'(song_done));
      if (reset && mon_en && (((act & ~1) != prev_ev) || song_done)) begin
        if (sb.size() == 0) begin
          check("unexpected output event", act, -1);
        end else begin
          e = sb.pop_front();
          check("event cycle", cyc, e.cyc);
          check("event value", act, e.val);
        end
      end
      prev_ev = act & ~1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    mon_en    = 1'b0;
    reset     = 1'b0;
    play_btn  = 1'b0;
    song_btn  = 2'b00;
    speed_btn = 2'b00;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic pulse_play();
    play_btn = 1'b1;
    tick();
    play_btn = 1'b0;
  endtask

  task automatic press_speed(input logic [1:0] b);
    speed_btn = b;
    tick();
    speed_btn = 2'b00;
    tick();
  endtask

  task automatic press_song(input logic [1:0] b);
    song_btn = b;
    tick();
    song_btn = 2'b00;
    tick();
  endtask

  task automatic scoreboard_drained(input string name);
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  int k, t;
  int s1_note[8] = '{1, 2, 3, 4, 5, 6, 7, 2};
  int s1_dur[8]  = '{0, 1, 0, 2, 0, 1, 0, 1};

  initial begin
    for (int s = 0; s < 3; s++) for (int p = 0; p < 8; p++) rom[s][p] = w(0, 15, 0);
    rom[0][0] = w(1, 1, 2);
    rom[0][1] = w(1, 3, 1);
    for (int p = 0; p < 8; p++) rom[1][p] = w(3, s1_note[p], s1_dur[p]);
    rom[2][0] = w(2, 5, 1);

    reset = 1'b1; play_btn = 1'b0; song_btn = 2'b00; speed_btn = 2'b00; loop_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("reset note_out", int'(note_out), 0);
    check("reset octave_out", int'(octave_out), 0);
    check("reset led_out", int'(led_out), 0);
    check("reset playing", int'(playing), 0);
    check("reset song_done", int'(song_done), 0);
    check("reset song_idx", int'(song_idx), 0);
    check("reset speed_idx", int'(speed_idx), 1);
    check("reset rom_song", int'(rom_song), 0);
    check("reset rom_pos", int'(rom_pos), 0);

    // One-shot: n1 d2 (8 cycles), n3 d1 (4 cycles), END
    do_reset();
    loop_en = 1'b0;
    mon_en  = 1'b1;
    k = cyc;
    pulse_play();
    push(k + 3, 1, 1, 0);
    push(k + 13, 3, 1, 0);
    push(k + 19, 0, 0, 1);
    wait_until(k + 5);
    check("playing during note", int'(playing), 1);
    check("rom_pos on first note", int'(rom_pos), 0);
    wait_until(k + 22);
    check("idle after one-shot", int'(playing), 0);
    scoreboard_drained("one-shot events drained");

    // Looping: note 1 returns without a song_done pulse
    do_reset();
    loop_en = 1'b1;
    mon_en  = 1'b1;
    k = cyc;
    pulse_play();
    push(k + 3, 1, 1, 0);
    push(k + 13, 3, 1, 0);
    push(k + 21, 1, 1, 0);
    push(k + 31, 3, 1, 0);
    wait_until(k + 34);
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    check("async reset note_out", int'(note_out), 0);
    check("async reset playing", int'(playing), 0);
    check("async reset rom_pos", int'(rom_pos), 0);
    scoreboard_drained("loop events drained");

    // Faster mid-note: remaining beats 2 cycles; speed wraps both ways
    do_reset();
    loop_en = 1'b0;
    mon_en  = 1'b1;
    k = cyc;
    pulse_play();
    push(k + 3, 1, 1, 0);
    push(k + 11, 3, 1, 0);
    push(k + 15, 0, 0, 1);
    wait_until(k + 4);
    speed_btn = 2'b01;
    tick();
    speed_btn = 2'b00;
    check("speed after faster", int'(speed_idx), 2);
    wait_until(k + 18);
    press_speed(2'b01);
    check("speed fast wraps to slow", int'(speed_idx), 0);
    press_speed(2'b10);
    check("speed slow wraps to fast", int'(speed_idx), 2);
    press_speed(2'b11);
    check("faster beats slower", int'(speed_idx), 0);
    scoreboard_drained("speed events drained");

    // Pause 20+ cycles mid-note; active note time unchanged
    do_reset();
    loop_en = 1'b0;
    mon_en  = 1'b1;
    k = cyc;
    pulse_play();
    push(k + 3, 1, 1, 0);
    push(k + 6, 0, 0, 0);
    push(k + 27, 1, 1, 0);
    push(k + 35, 3, 1, 0);
    push(k + 41, 0, 0, 1);
    wait_until(k + 5);
    pulse_play();
    check("led dark on pause", int'(led_out), 0);
    check("not playing when paused", int'(playing), 0);
    wait_until(k + 16);
    check("note silent mid-pause", int'(note_out), 0);
    wait_until(k + 26);
    pulse_play();
    wait_until(k + 44);
    scoreboard_drained("pause events drained");

    // Prev at song 0 during note 3 jumps to song 2 from pos 0
    do_reset();
    loop_en = 1'b0;
    mon_en  = 1'b1;
    k = cyc;
    pulse_play();
    push(k + 3, 1, 1, 0);
    push(k + 13, 3, 1, 0);
    push(k + 17, 5, 2, 0);
    push(k + 23, 0, 0, 1);
    wait_until(k + 14);
    check("rom_pos before song step", int'(rom_pos), 1);
    song_btn = 2'b10;
    tick();
    song_btn = 2'b00;
    check("prev wraps song_idx", int'(song_idx), 2);
    check("prev sets rom_song", int'(rom_song), 2);
    check("song step resets rom_pos", int'(rom_pos), 0);
    check("song step keeps playing", int'(playing), 1);
    wait_until(k + 26);
    press_song(2'b11);
    check("next beats prev", int'(song_idx), 0);
    check("song step in idle stays idle", int'(playing), 0);
    scoreboard_drained("song step events drained");

    // Eight-note song, dur 0 = one beat; one-shot then looping
    for (int lp = 0; lp < 2; lp++) begin
      do_reset();
      loop_en = lp[0];
      press_song(2'b01);
      check("next selects song 1", int'(song_idx), 1);
      mon_en = 1'b1;
      k = cyc;
      pulse_play();
      t = k + 3;
      for (int i = 0; i < 8; i++) begin
        push(t, s1_note[i], 3, 0);
        if (i < 7) t = t + 4 * ((s1_dur[i] == 0) ? 1 : s1_dur[i]) + 2;
      end
      if (lp == 0) begin
        push(t + 4, 0, 0, 1);
        wait_until(t + 7);
        check("idle after last position", int'(playing), 0);
      end else begin
        push(t + 6, 1, 3, 0);
        wait_until(t + 7);
        check("rom_pos wraps to 0", int'(rom_pos), 0);
        mon_en = 1'b0;
      end
      scoreboard_drained("full song events drained");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
